wb_stage: RTL and testbench

- Write-back stage, directly downstream of the memory-access stage. Last stage of the main pipeline.
- Holds one instruction in an inter-stage register.
- Captures the data-bus read response, including when it arrives while the memory stage is still blocked.
- Performs load extraction (LB/LBU/LH/LHU/LW/LWL/LWR) and drives the GPR write port, ID-stage forwarding, exception-risk interlock and the debug trace.

---
 rtl/wb_stage_pkg.sv | 18 +
 rtl/wb_stage_load_align.sv | 50 +++++
 rtl/wb_stage.sv | 142 ++++++++++++++
 tb/tb_wb_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared encodings and widths for the write-back stage.
package wb_stage_pkg;
  localparam int GPR_NUM     = 5;
  localparam int SINGLE_WORD = 32;
  localparam int EXCEP_SEG   = 5;  // IF, ID, EX, MEM, WB
  localparam int EXCEP_WB    = 4;

  typedef enum logic [2:0] {
    LS_LW   = 3'd0,
    LS_LB   = 3'd1,
    LS_LBU  = 3'd2,
    LS_LH   = 3'd3,
    LS_LHU  = 3'd4,
    LS_LWL  = 3'd5,
    LS_LWR  = 3'd6,
    LS_NONE = 3'd7
  } load_sel_e;
endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: picks/extends the addressed bytes and
// merges unaligned LWL/LWR words into the old rt value.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  loadSel_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] rtData_i,
  output logic [31:0] result_o,
  output logic [3:0]  byteMask_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic        partial;

  // Select/extend per load type; partial loads merge under a byte mask.
  always_comb begin
    byte_sel   = word_i[{offset_i, 3'b000} +: 8];
    half_sel   = offset_i[1] ? word_i[31:16] : word_i[15:0];
    sh         = {offset_i, 3'b000};
    shifted    = word_i;
    partial    = 1'b0;
    result_o   = word_i;
    byteMask_o = 4'b1111;
    case (load_sel_e'(loadSel_i))
      LS_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LS_LBU: result_o = {24'd0, byte_sel};
      LS_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      LS_LHU: result_o = {16'd0, half_sel};
      LS_LWL: begin
        partial    = 1'b1;
        shifted    = word_i << (5'd24 - sh);
        byteMask_o = 4'b1111 << (2'd3 - offset_i);
      end
      LS_LWR: begin
        partial    = 1'b1;
        shifted    = word_i >> sh;
        byteMask_o = 4'b1111 >> offset_i;
      end
      default: result_o = word_i;
    endcase
    if (partial) begin
      for (int i = 0; i < 4; i++)
        result_o[8*i +: 8] = byteMask_o[i] ? shifted[8*i +: 8] : rtData_i[8*i +: 8];
    end
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction, buffers early bus responses,
// extracts load data and drives the GPR write port, forwarding and trace.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = SINGLE_WORD,
  parameter int GPR_W  = GPR_NUM,
  parameter int LSEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_valid_w_i,
  output logic                 WB_allowin_w_o,
  input  logic                 CP0_excOccur_w_i,
  input  logic [EXCEP_SEG-1:0] CP0_exceptSeg_w_i,
  input  logic                 data_data_ok,
  input  logic [DATA_W-1:0]    data_rdata,
  input  logic [GPR_W-1:0]     MEM_writeNum_i,
  input  logic [DATA_W-1:0]    MEM_VAddr_i,
  input  logic [DATA_W-1:0]    MEM_finalRes_i,
  input  logic [DATA_W-1:0]    MEM_rtData_i,
  input  logic                 MEM_memReq_i,
  input  logic [LSEL_W-1:0]    MEM_loadSel_i,
  input  logic [1:0]           MEM_alignCheck_i,
  input  logic                 MEM_isDangerous_i,
  input  logic                 MEM_exceptionRisk_i,
  output logic                 WB_dataPending_w_o,
  output logic                 WB_hasRisk_w_o,
  output logic                 WB_hasDangerous_w_o,
  output logic                 WB_forwardMode_w_o,
  output logic [GPR_W-1:0]     WB_writeNum_w_o,
  output logic [DATA_W-1:0]    WB_writeData_w_o,
  output logic                 WB_rfWe_o,
  output logic [GPR_W-1:0]     WB_rfNum_o,
  output logic [DATA_W-1:0]    WB_rfData_o,
  output logic [DATA_W-1:0]    debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [GPR_W-1:0]     debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata
);
  logic              flush;
  logic              hasData_q;
  logic [DATA_W-1:0] pc_q, finalRes_q, rtData_q, loadWord_q;
  logic [GPR_W-1:0]  writeNum_q;
  logic              memReq_q, dang_q, risk_q;
  logic [LSEL_W-1:0] loadSel_q;
  logic [1:0]        align_q;
  logic [DATA_W-1:0] rdBuf_q, rdBuf_d;
  logic              rdBufValid_q, rdBufValid_d;
  logic [DATA_W-1:0] ld_res, wdata;
  logic [3:0]        ld_mask, mask;
  logic              we;

  assign flush = CP0_excOccur_w_i && CP0_exceptSeg_w_i[EXCEP_WB];

  // Response buffer: a word arriving with no instruction presented is held
  // until the consuming load shows up; a second response cannot legally
  // arrive while one is buffered, so the held word is never overwritten.
  always_comb begin
    rdBuf_d      = rdBuf_q;
    rdBufValid_d = rdBufValid_q;
    if (flush) begin
      rdBufValid_d = 1'b0;
    end else if (MEM_valid_w_i && MEM_memReq_i) begin
      rdBufValid_d = 1'b0;
    end else if (data_data_ok && !MEM_valid_w_i && !rdBufValid_q) begin
      rdBuf_d      = data_rdata;
      rdBufValid_d = 1'b1;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdBuf_q      <= '0;
      rdBufValid_q <= 1'b0;
    end else begin
      rdBuf_q      <= rdBuf_d;
      rdBufValid_q <= rdBufValid_d;
    end
  end

  // Stage register; payload loads on valid, occupancy is cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hasData_q  <= 1'b0;
      pc_q       <= '0;
      finalRes_q <= '0;
      rtData_q   <= '0;
      loadWord_q <= '0;
      writeNum_q <= '0;
      memReq_q   <= 1'b0;
      dang_q     <= 1'b0;
      risk_q     <= 1'b0;
      loadSel_q  <= '0;
      align_q    <= '0;
    end else begin
      hasData_q <= MEM_valid_w_i && !flush;
      if (MEM_valid_w_i) begin
        pc_q       <= MEM_VAddr_i;
        finalRes_q <= MEM_finalRes_i;
        rtData_q   <= MEM_rtData_i;
        writeNum_q <= MEM_writeNum_i;
        memReq_q   <= MEM_memReq_i;
        dang_q     <= MEM_isDangerous_i;
        risk_q     <= MEM_exceptionRisk_i;
        loadSel_q  <= MEM_loadSel_i;
        align_q    <= MEM_alignCheck_i;
        if (MEM_memReq_i)
          loadWord_q <= rdBufValid_q ? rdBuf_q : data_rdata;
      end
    end
  end

  wb_stage_load_align u_align (
    .loadSel_i (loadSel_q),
    .offset_i  (align_q),
    .word_i    (loadWord_q),
    .rtData_i  (rtData_q),
    .result_o  (ld_res),
    .byteMask_o(ld_mask)
  );

  assign wdata = memReq_q ? ld_res  : finalRes_q;
  assign mask  = memReq_q ? ld_mask : 4'b1111;
  assign we    = hasData_q && (writeNum_q != '0);

  assign WB_allowin_w_o      = 1'b1;
  assign WB_dataPending_w_o  = rdBufValid_q;
  assign WB_hasRisk_w_o      = hasData_q && risk_q;
  assign WB_hasDangerous_w_o = hasData_q && dang_q;
  assign WB_forwardMode_w_o  = hasData_q;
  assign WB_writeNum_w_o     = writeNum_q;
  assign WB_writeData_w_o    = wdata;
  assign WB_rfWe_o           = we;
  assign WB_rfNum_o          = writeNum_q;
  assign WB_rfData_o         = wdata;
  assign debug_wb_pc         = pc_q;
  assign debug_wb_rf_wen     = we ? mask : 4'b0000;
  assign debug_wb_rf_wnum    = writeNum_q;
  assign debug_wb_rf_wdata   = wdata;
endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage with a byte-level reference model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid, allowin, exc, dok, memReq, dang, risk;
  logic [EXCEP_SEG-1:0] seg;
  logic [31:0]          rdata, vaddr, fres, rt;
  logic [4:0]           wnum;
  logic [2:0]           lsel;
  logic [1:0]           align;
  logic                 pend, hrisk, hdang, fwd, rfWe;
  logic [4:0]           fnum, rfNum, dwnum;
  logic [31:0]          fdata, rfData, dpc, dwdata;
  logic [3:0]           dwen;

  int vectors = 0, miscompares = 0;

  // model state
  logic        m_has, m_bufv, m_risk, m_dang;
  logic [31:0] m_buf, m_pc, m_data;
  logic [4:0]  m_num;
  logic [3:0]  m_mask;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .MEM_valid_w_i(valid), .WB_allowin_w_o(allowin),
    .CP0_excOccur_w_i(exc), .CP0_exceptSeg_w_i(seg),
    .data_data_ok(dok), .data_rdata(rdata),
    .MEM_writeNum_i(wnum), .MEM_VAddr_i(vaddr), .MEM_finalRes_i(fres),
    .MEM_rtData_i(rt), .MEM_memReq_i(memReq), .MEM_loadSel_i(lsel),
    .MEM_alignCheck_i(align), .MEM_isDangerous_i(dang),
    .MEM_exceptionRisk_i(risk), .WB_dataPending_w_o(pend),
    .WB_hasRisk_w_o(hrisk), .WB_hasDangerous_w_o(hdang),
    .WB_forwardMode_w_o(fwd), .WB_writeNum_w_o(fnum),
    .WB_writeData_w_o(fdata), .WB_rfWe_o(rfWe), .WB_rfNum_o(rfNum),
    .WB_rfData_o(rfData), .debug_wb_pc(dpc), .debug_wb_rf_wen(dwen),
    .debug_wb_rf_wnum(dwnum), .debug_wb_rf_wdata(dwdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load semantics expressed byte by byte.
  function automatic void ref_load(input logic [2:0] sel, input logic [1:0] a,
                                   input logic [31:0] w, input logic [31:0] r,
                                   output logic [31:0] res, output logic [3:0] msk);
    logic [7:0] wb [4];
    logic [7:0] rb [4];
    int ai, h;
    ai = int'(a);
    for (int i = 0; i < 4; i++) begin
      wb[i] = w[8*i +: 8];
      rb[i] = r[8*i +: 8];
    end
    msk = 4'hF;
    res = w;
    case (sel)
      3'd1, 3'd2: begin
        res = 32'(wb[ai]);
        if (sel == 3'd1 && wb[ai] >= 8'd128) res = res - 32'd256;
      end
      3'd3, 3'd4: begin
        h = int'(w >> (16 * (ai / 2))) & 32'hFFFF;
        res = 32'(h);
        if (sel == 3'd3 && h >= 32768) res = res - 32'd65536;
      end
      3'd5: for (int i = 0; i < 4; i++) begin
        msk[i] = (i >= 3 - ai);
        res[8*i +: 8] = msk[i] ? wb[i - (3 - ai)] : rb[i];
      end
      3'd6: for (int i = 0; i < 4; i++) begin
        msk[i] = (i <= 3 - ai);
        res[8*i +: 8] = msk[i] ? wb[i + ai] : rb[i];
      end
      default: res = w;
    endcase
  endfunction

  task automatic idle();
    valid = 0; exc = 0; seg = '0; dok = 0; memReq = 0; dang = 0; risk = 0;
    lsel = 3'd7; align = 0; wnum = 0; vaddr = 0; fres = 0; rt = 0; rdata = 0;
  endtask

  task automatic model_reset();
    m_has = 0; m_bufv = 0; m_buf = 0; m_pc = 0; m_data = 0; m_num = 0;
    m_mask = 4'hF; m_risk = 0; m_dang = 0;
  endtask

  task automatic check_outputs();
    logic we;
    we = m_has && (m_num != 0);
    chk("allowin", allowin, 1);
    chk("rfWe", rfWe, we);
    chk("wen", dwen, we ? m_mask : 4'h0);
    chk("hasRisk", hrisk, m_has && m_risk);
    chk("hasDang", hdang, m_has && m_dang);
    chk("fwd", fwd, m_has);
    chk("pending", pend, m_bufv);
    if (m_has) begin
      chk("rfNum", rfNum, m_num);
      chk("rfData", rfData, m_data);
      chk("fwdNum", fnum, m_num);
      chk("fwdData", fdata, m_data);
      chk("dbgNum", dwnum, m_num);
      chk("dbgData", dwdata, m_data);
      chk("dbgPc", dpc, m_pc);
    end
  endtask

  // Apply current inputs for one clock and check the registered result.
  task automatic do_cycle();
    logic flush;
    logic [31:0] word;
    flush = exc && seg[EXCEP_WB];
    if (valid) begin
      m_pc = vaddr; m_num = wnum; m_risk = risk; m_dang = dang;
      if (memReq) begin
        word = m_bufv ? m_buf : rdata;
        ref_load(lsel, align, word, rt, m_data, m_mask);
      end else begin
        m_data = fres; m_mask = 4'hF;
      end
    end
    m_has = valid && !flush;
    if (flush) m_bufv = 0;
    else if (valid && memReq) m_bufv = 0;
    else if (dok && !valid && !m_bufv) begin m_buf = rdata; m_bufv = 1; end
    @(posedge clk); #1;
    check_outputs();
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_allowin"}, allowin, 1);
    chk({tag, "_outs"}, {pend, hrisk, hdang, fwd, rfWe, dwen}, 0);
    chk({tag, "_nums"}, {fnum, rfNum, dwnum}, 0);
    chk({tag, "_data"}, fdata | rfData | dwdata, 0);
    chk({tag, "_pc"}, dpc, 0);
  endtask

  task automatic load(input logic [2:0] s, input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] r);
    valid = 1; memReq = 1; lsel = s; align = a; dok = 1; rdata = d; rt = r;
    wnum = 5'd9; vaddr = 32'hBFC0_0100;
  endtask

  initial begin
    idle(); model_reset();
    #1 check_all_zero("reset");
    @(negedge clk) rst = 0;

    // ALU result
    valid = 1; fres = 32'h12345678; wnum = 5; vaddr = 32'hBFC0_0000;
    do_cycle();
    chk("alu_data", rfData, 32'h12345678);
    chk("alu_we", {rfWe, rfNum, dwen}, {1'b1, 5'd5, 4'b1111});

    load(3'd1, 2'd2, 32'h80FF7F01, 0); do_cycle(); chk("lb", rfData, 32'hFFFFFFFF);
    load(3'd2, 2'd2, 32'h80FF7F01, 0); do_cycle(); chk("lbu", rfData, 32'h000000FF);
    load(3'd3, 2'd2, 32'h80FF7F01, 0); do_cycle(); chk("lh", rfData, 32'hFFFF80FF);
    load(3'd5, 2'd1, 32'h11223344, 32'hAABBCCDD); do_cycle();
    chk("lwl", rfData, 32'h3344CCDD); chk("lwl_wen", dwen, 4'b1100);
    load(3'd6, 2'd2, 32'h11223344, 32'hAABBCCDD); do_cycle();
    chk("lwr", rfData, 32'hAABB1122); chk("lwr_wen", dwen, 4'b0011);

    // early response, consumed three cycles later
    dok = 1; rdata = 32'hCAFEF00D; do_cycle();
    chk("early_pend", pend, 1);
    do_cycle(); do_cycle();
    load(3'd0, 2'd0, 32'h5555AAAA, 0); dok = 0; do_cycle();
    chk("early_data", rfData, 32'hCAFEF00D); chk("early_pend_clr", pend, 0);

    // flush with an instruction and a buffered word held
    dok = 1; rdata = 32'h0BADBEEF; do_cycle();
    valid = 1; wnum = 7; fres = 32'h77; risk = 1; do_cycle();
    chk("pre_flush", {rfWe, hrisk, pend}, 3'b111);
    exc = 1; seg = 5'b10000; do_cycle();
    chk("flush", {rfWe, dwen, hrisk, pend}, 0);
    valid = 1; wnum = 4; exc = 1; seg = 5'b11111; do_cycle();
    chk("flush_prio", rfWe, 0);
    valid = 1; wnum = 0; fres = 32'h1; do_cycle();
    chk("r0_we", {rfWe, dwen}, 0);

    // reset mid-stream with instruction and buffer held
    dok = 1; rdata = 32'h01020304; do_cycle();
    valid = 1; wnum = 12; fres = 32'hFACE; risk = 1; dang = 1; do_cycle();
    rst = 1; #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk) rst = 0;
    valid = 1; wnum = 3; fres = 32'h600D; do_cycle();
    chk("post_rst", {rfWe, rfNum}, {1'b1, 5'd3});
    dok = 1; rdata = 32'h13572468; do_cycle();
    chk("post_rst_cap", pend, 1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      valid  = ($urandom_range(0, 9) < 7);
      memReq = valid && $urandom_range(0, 1);
      lsel   = memReq ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
      align  = 2'($urandom);
      wnum   = 5'($urandom);
      vaddr  = $urandom; fres = $urandom; rt = $urandom; rdata = $urandom;
      dang   = 1'($urandom); risk = 1'($urandom);
      exc    = ($urandom_range(0, 9) == 0);
      seg    = EXCEP_SEG'($urandom);
      if (valid && memReq) dok = !m_bufv;
      else if (!valid)     dok = !m_bufv && ($urandom_range(0, 2) == 0);
      else                 dok = 0;
      do_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
